// File: rtl/accel_filter.sv
// Per-channel power-of-two moving-average filter with tick-paced, valid/ready framed output.
// Define ACCEL_FILTER_SAT_EN to saturate the width reduction instead of truncating it.
module accel_filter #(
   parameter int NUM_CH   = 3,
   parameter int IN_W     = 16,
   parameter int OUT_W    = 10,
   parameter int AVG_LOG2 = 2,
   parameter int TICK_DIV = 10_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [NUM_CH*IN_W-1:0]    in_data,
   input  logic                      freeze,
   input  logic                      out_ready,
   output logic [NUM_CH*OUT_W-1:0]   out_data,
   output logic                      out_valid,
   output logic                      overrun,
   output logic                      primed
);

   localparam int D     = 1 << AVG_LOG2;
   localparam int SUM_W = IN_W + AVG_LOG2;
   localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef ACCEL_FILTER_SAT_EN
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;
`endif

   typedef enum logic [1:0] {EMPTY, FILLING, RUN} fill_t;

   fill_t                   state, state_nx;
   logic signed [IN_W-1:0]  hist   [NUM_CH][D];
   logic signed [SUM_W-1:0] sum    [NUM_CH];
   logic signed [SUM_W-1:0] sum_nx [NUM_CH];
   logic [OUT_W-1:0]        avg    [NUM_CH];
   logic [PW-1:0]           wp;
   logic [CW-1:0]           tick_cnt;
   logic                    tick;
   logic                    snap;

   function automatic logic [OUT_W-1:0] reduce(input logic signed [SUM_W-1:0] s);
`ifdef ACCEL_FILTER_SAT_EN
      logic signed [SUM_W-1:0] a;
      a = s >>> AVG_LOG2;
      if (a > SAT_HI) return SAT_HI[OUT_W-1:0];
      if (a < SAT_LO) return SAT_LO[OUT_W-1:0];
      return a[OUT_W-1:0];
`else
      return OUT_W'(s >>> AVG_LOG2);
`endif
   endfunction

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         sum_nx[c] = sum[c] + SUM_W'(signed'(in_data[c*IN_W +: IN_W])) - SUM_W'(hist[c][wp]);
      end
   end

   // Fill tracking: the D-th accepted sample is the one written at wp == D-1.
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (in_valid) state_nx = (D == 1) ? RUN : FILLING;
         FILLING: if (in_valid && wp == PW'(D - 1)) state_nx = RUN;
         RUN:     state_nx = RUN;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= state_nx;
   end

   assign primed = (state == RUN);
   assign tick   = (tick_cnt == CW'(TICK_DIV - 1));
   assign snap   = tick && primed && !freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + CW'(1);
   end

   // avg is held already reduced to OUT_W; the reduction is a pure function of the average.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum[c] <= '0;
            avg[c] <= '0;
            for (int unsigned k = 0; k < D; k++) hist[c][k] <= '0;
         end
      end else if (in_valid) begin
         wp <= (wp == PW'(D - 1)) ? '0 : wp + PW'(1);
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum[c]      <= sum_nx[c];
            hist[c][wp] <= signed'(in_data[c*IN_W +: IN_W]);
            avg[c]      <= reduce(sum_nx[c]);
         end
      end
   end

   // A snapshot outranks a coincident acceptance: the new frame stays pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (snap) begin
         for (int unsigned c = 0; c < NUM_CH; c++) out_data[c*OUT_W +: OUT_W] <= avg[c];
         out_valid <= 1'b1;
         if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_accel_filter.sv
// Randomized scoreboard bench for accel_filter: a sample-history reference model predicts frames,
// a negedge monitor compares delivered frames and status outputs.
module tb_accel_filter;

   localparam int NUM_CH = 3;
   localparam int IN_W   = 16;
   localparam int OUT_W  = 10;
   localparam int AVG_L  = 2;
   localparam int D      = 4;
   localparam int TDIV   = 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    in_valid = 1'b0;
   logic [NUM_CH*IN_W-1:0]  in_data = '0;
   logic                    freeze = 1'b0;
   logic                    out_ready = 1'b1;
   logic [NUM_CH*OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    overrun;
   logic                    primed;

   int total = 0;
   int bad   = 0;

   accel_filter #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_L), .TICK_DIV(TDIV)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .freeze(freeze),
      .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid), .overrun(overrun),
      .primed(primed)
   );

   always #5 clk = ~clk;

   // Reference model state
   int                      hist [NUM_CH][$];
   int                      n_samples = 0;
   int                      cyc = 0;
   bit                      m_valid = 1'b0;
   bit                      m_ovr = 1'b0;
   logic [NUM_CH*OUT_W-1:0] m_data = '0;
   logic [NUM_CH*OUT_W-1:0] exp_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] reduce(input int a);
      logic [31:0] v;
`ifdef ACCEL_FILTER_SAT_EN
      if (a > 511)  return 10'h1FF;
      if (a < -512) return 10'h200;
`endif
      v = a;
      return v[OUT_W-1:0];
   endfunction

   function automatic logic [NUM_CH*OUT_W-1:0] model_frame();
      logic [NUM_CH*OUT_W-1:0] f;
      int s;
      f = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         s = 0;
         foreach (hist[c][k]) s += hist[c][k];
         f[c*OUT_W +: OUT_W] = reduce(s >>> AVG_L);   // floor(s / D)
      end
      return f;
   endfunction

   // Reference model: evaluated at each edge using inputs as they stand before it
   initial begin
      logic [NUM_CH*OUT_W-1:0] fr;
      logic [IN_W-1:0] w;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) hist[c].delete();
            n_samples = 0; cyc = 0; m_valid = 0; m_ovr = 0; m_data = '0;
            exp_q.delete();
         end else begin
            if ((cyc % TDIV) == TDIV - 1 && n_samples >= D && !freeze) begin
               fr = model_frame();
               if (m_valid && !out_ready) begin
                  m_ovr = 1'b1;
                  if (exp_q.size() > 0) exp_q[exp_q.size()-1] = fr;
                  else exp_q.push_back(fr);
               end else begin
                  exp_q.push_back(fr);
               end
               m_valid = 1'b1;
               m_data  = fr;
            end else if (m_valid && out_ready) begin
               m_valid = 1'b0;
            end
            if (in_valid) begin
               for (int c = 0; c < NUM_CH; c++) begin
                  w = in_data[c*IN_W +: IN_W];
                  hist[c].push_back(int'($signed(w)));
                  if (hist[c].size() > D) void'(hist[c].pop_front());
               end
               n_samples++;
            end
            cyc++;
         end
      end
   end

   // Monitor: status every cycle, frames popped from the scoreboard on acceptance
   initial begin
      logic [NUM_CH*OUT_W-1:0] e;
      forever begin
         @(negedge clk);
         chk("primed", primed, n_samples >= D);
         chk("out_valid", out_valid, m_valid);
         chk("overrun", overrun, m_ovr);
         chk("out_data_hold", out_data, m_data);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("frame_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("frame", out_data, e);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [NUM_CH*IN_W-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
   endtask

   function automatic logic [IN_W-1:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'(int'($urandom_range(0, 40)) - 20);
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [NUM_CH*IN_W-1:0] rnd_set();
      logic [NUM_CH*IN_W-1:0] d;
      for (int c = 0; c < NUM_CH; c++) d[c*IN_W +: IN_W] = rnd_word();
      return d;
   endfunction

   function automatic logic [NUM_CH*IN_W-1:0] all_ch(input logic [IN_W-1:0] v);
      return {NUM_CH{v}};
   endfunction

   initial begin
      logic [NUM_CH*IN_W-1:0] d;
      step(3);
      chk("reset_out_data", out_data, '0);
      chk("reset_out_valid", out_valid, 0);
      rst = 1'b1;

      // Priming
      for (int i = 0; i < 3; i++) send(rnd_set());
      step(12);
      chk("not_primed_after_3", primed, 0);
      chk("no_frame_before_prime", out_valid, 0);
      send(rnd_set());
      step(10);

      // Averaging on channel 0
      foreach (d[i]) d[i] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = rnd_set();
         d[IN_W-1:0] = (i < 2) ? 16'd100 : 16'd200;
         send(d);
      end
      step(10);
      chk("avg_150", out_data[OUT_W-1:0], 10'h096);
      d = rnd_set();
      d[IN_W-1:0] = 16'd200;
      send(d);
      step(10);
      chk("avg_175", out_data[OUT_W-1:0], 10'h0AF);

      // Reduction boundaries
      for (int i = 0; i < 4; i++) send(all_ch(16'h7FFF));
      step(10);
`ifdef ACCEL_FILTER_SAT_EN
      chk("reduce_max", out_data[OUT_W-1:0], 10'h1FF);
`else
      chk("reduce_max", out_data[OUT_W-1:0], 10'h3FF);
`endif
      for (int i = 0; i < 4; i++) send(all_ch(16'hFFFC));
      step(10);
      chk("reduce_neg4", out_data[OUT_W-1:0], 10'h3FC);

      // Handshake / overrun
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(rnd_set());
      step(6);
      for (int i = 0; i < 4; i++) send(rnd_set());
      step(6);
      chk("overrun_set", overrun, 1);
      chk("valid_held", out_valid, 1);
      out_ready = 1'b1;
      step(3);
      chk("overrun_sticky", overrun, 1);

      // Freeze
      freeze = 1'b1;
      for (int i = 0; i < 3 * TDIV; i++) begin
         if (i % 3 == 0) send(rnd_set()); else step(1);
      end
      freeze = 1'b0;
      step(2 * TDIV);

      // Randomized traffic with back-pressure, bursts and freeze
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (i % 50 == 0) freeze = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 1) send(rnd_set()); else step(1);
      end
      freeze = 1'b0;
      out_ready = 1'b1;
      step(2 * TDIV);

      // Reset mid-fill
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) send(rnd_set());
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) send(rnd_set());
      step(3 * TDIV);
      chk("midfill_not_primed", primed, 0);
      chk("midfill_no_frame", out_valid, 0);
      send(rnd_set());
      step(2 * TDIV);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
